// File: rtl/dff_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_pkg
// Purpose  : Shared types, step table and per-bit configuration decode for
//            the 64-instance DFF checker.
// Revision : 1.0 - initial release
// ============================================================================
package dff_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic clk_inv;
    logic en_inv;
    logic sr_inv;
    logic sr_val;
    logic init;
    logic d;
  } bit_cfg_t;

  localparam int unsigned c_hold_default = 4;
  localparam int unsigned c_nbits        = 64;
  localparam logic [9:0]  c_err_max      = 10'd1023;
  localparam logic [2:0]  c_no_fail      = 3'd7;

  // Bit s of each vector is the (en, sr) pair of step s.
  localparam logic [7:0] c_step_en = 8'b0011_0010;
  localparam logic [7:0] c_step_sr = 8'b0101_1000;

  // Instance index i = k >> 1, so i[n] lives at k[n+1]; D is k[0].
  function automatic bit_cfg_t decode_bit(input logic [5:0] k);
    bit_cfg_t cfg;
    cfg.clk_inv = k[1];
    cfg.en_inv  = k[2];
    cfg.sr_inv  = k[3];
    cfg.sr_val  = k[4];
    cfg.init    = k[5];
    cfg.d       = k[0];
    return cfg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dff_chk_model.sv
`default_nettype none
// ============================================================================
// Module   : dff_chk_model
// Purpose  : 64-bit expected-state register mirroring the DFF array under test.
// Revision : 1.0 - initial release
// ============================================================================
module dff_chk_model
  import dff_chk_pkg::*;
(
  input  logic        clk,
  input  logic        en,
  input  logic        sr,
  input  logic        init,
  input  logic        update,
  output logic [63:0] model_next
);

  logic [63:0] r_model;
  logic [63:0] w_init_vec;

  generate
    for (genvar k = 0; k < 64; k++) begin : g_bit
      localparam bit_cfg_t c_cfg = decode_bit(6'(k));

      assign w_init_vec[k] = c_cfg.init;
      // SR dominates EN; the clock polarity has no bearing on the settled value.
      assign model_next[k] = (sr ^ c_cfg.sr_inv) ? c_cfg.sr_val :
                             (en ^ c_cfg.en_inv) ? c_cfg.d      :
                                                   r_model[k];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (init) begin
      r_model <= w_init_vec;
    end else if (update) begin
      r_model <= model_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : dff_checker
// Purpose  : Drives a common EN/SR step sequence into 64 DFF instances and
//            counts Q bits that disagree with the expected model.
// Revision : 1.0 - initial release
// ============================================================================
module dff_checker
  import dff_chk_pkg::*;
#(
  parameter int HOLD  = c_hold_default,
  parameter int NSTEP = 8
) (
  input  logic        clk,
  input  logic        sr,
  input  logic        start,
  output logic        dut_en,
  output logic        dut_sr,
  input  logic [63:0] dut_q,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [9:0]  err_count,
  output logic [2:0]  first_fail_step
);

  state_t      r_state;
  logic [3:0]  r_hold;
  logic [2:0]  r_step;
  logic [63:0] r_q_cap;

  logic [63:0] w_model_next;
  logic [2:0]  w_step_nxt;
  logic        w_last_hold;
  logic        w_last_step;
  logic        w_start_run;
  logic        w_compare;
  logic        w_init;
  logic        w_update;
  logic [6:0]  w_mismatch;
  logic [10:0] w_err_sum;
  logic [9:0]  w_err_next;

  assign w_step_nxt  = r_step + 3'd1;
  assign w_last_hold = (r_hold == 4'(HOLD - 1));
  assign w_last_step = (r_step == 3'(NSTEP - 1));
  assign w_start_run = start && (r_state != ST_RUN);
  assign w_compare   = (r_state == ST_RUN) && w_last_hold;
  assign w_init      = sr || w_start_run;
  assign w_update    = !sr && w_compare;

  assign w_mismatch  = 7'($countones(r_q_cap ^ w_model_next));
  assign w_err_sum   = {1'b0, err_count} + {4'b0000, w_mismatch};
  assign w_err_next  = w_err_sum[10] ? c_err_max : w_err_sum[9:0];

  dff_chk_model u_model (
    .clk        (clk),
    .en         (dut_en),
    .sr         (dut_sr),
    .init       (w_init),
    .update     (w_update),
    .model_next (w_model_next)
  );

  always_ff @(posedge clk) begin
    if (sr) begin
      r_q_cap <= '0;
    end else begin
      r_q_cap <= dut_q;
    end
  end

  always_ff @(posedge clk) begin
    if (sr) begin
      r_state         <= ST_IDLE;
      r_hold          <= '0;
      r_step          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_step <= c_no_fail;
      dut_en          <= 1'b0;
      dut_sr          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          dut_en <= 1'b0;
          dut_sr <= 1'b0;
          if (w_start_run) begin
            r_state         <= ST_RUN;
            r_hold          <= '0;
            r_step          <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_step <= c_no_fail;
            dut_en          <= c_step_en[0];
            dut_sr          <= c_step_sr[0];
          end
        end

        ST_RUN: begin
          if (w_last_hold) begin
            r_hold    <= '0;
            err_count <= w_err_next;
            // A zero count means no earlier step of this run has mismatched.
            if ((w_mismatch != 7'd0) && (err_count == 10'd0)) begin
              first_fail_step <= r_step;
            end
            if (w_last_step) begin
              r_state <= ST_DONE;
              r_step  <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (w_err_next == 10'd0);
              dut_en  <= 1'b0;
              dut_sr  <= 1'b0;
            end else begin
              r_step <= w_step_nxt;
              dut_en <= c_step_en[w_step_nxt];
              dut_sr <= c_step_sr[w_step_nxt];
            end
          end else begin
            r_hold <= r_hold + 4'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
          dut_en  <= 1'b0;
          dut_sr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dff_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_checker
// Purpose  : Directed bench: behavioural 64-DFF loopback with fault masks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_checker;

  localparam int HOLD  = 4;
  localparam int NSTEP = 8;

  typedef struct {
    int   err;
    int   ffs;
    logic pass;
  } exp_t;

  logic        clk   = 1'b0;
  logic        sr    = 1'b1;
  logic        start = 1'b0;
  logic        dut_en, dut_sr, busy, done, pass;
  logic [9:0]  err_count;
  logic [2:0]  first_fail_step;
  logic [63:0] dut_q;
  logic [63:0] q_arr;
  logic [63:0] sa0 = '0;
  logic [63:0] sa1 = '0;
  logic [63:0] inv = '0;
  logic [7:0]  tab_en = 8'b0011_0010;
  logic [7:0]  tab_sr = 8'b0101_1000;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  dff_checker #(.HOLD(HOLD), .NSTEP(NSTEP)) u_dut (
    .clk             (clk),
    .sr              (sr),
    .start           (start),
    .dut_en          (dut_en),
    .dut_sr          (dut_sr),
    .dut_q           (dut_q),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (err_count),
    .first_fail_step (first_fail_step)
  );

  function automatic logic kb(input int k, input int n);
    return logic'((k >> n) & 1);
  endfunction

  // Ideal DFF array: bit k = 2*i + j; clk_inv=k[1] en_inv=k[2] sr_inv=k[3]
  // sr_val=k[4] init=k[5] d=k[0]. Reloaded with INIT whenever a run starts.
  always @(posedge clk or negedge clk) begin
    for (int k = 0; k < 64; k++) begin
      if (clk && (sr || (start && !busy))) begin
        q_arr[k] <= kb(k, 5);
      end else if (kb(k, 1) == !clk) begin
        if (dut_sr ^ kb(k, 3))      q_arr[k] <= kb(k, 4);
        else if (dut_en ^ kb(k, 2)) q_arr[k] <= kb(k, 0);
      end
    end
  end

  assign dut_q = ((q_arr & ~sa0) | sa1) ^ inv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge following RUN entry; returns at the negedge done is seen.
  task automatic collect();
    int   nbusy;
    logic got;
    exp_t e;
    nbusy = 0;
    got   = 1'b0;
    for (int c = 0; c < 20 * NSTEP * HOLD && !got; c++) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy === 1'b1) begin
          check("stim_en_sr", 32'({dut_en, dut_sr}),
                32'({tab_en[3'(nbusy / HOLD)], tab_sr[3'(nbusy / HOLD)]}));
          nbusy++;
        end
        @(negedge clk);
      end
    end
    check("done_seen", 32'(got), 32'd1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (got) begin
        check("busy_cycles", 32'(nbusy), 32'(NSTEP * HOLD));
        check("busy_at_done", 32'(busy), 32'd0);
        check("err_count", 32'(err_count), 32'(e.err));
        check("first_fail_step", 32'(first_fail_step), 32'(e.ffs));
        check("pass", 32'(pass), 32'(e.pass));
      end
    end
  endtask

  task automatic pulse_run(input int err, input int ffs);
    sb.push_back('{err, ffs, (err == 0)});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    collect();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"}, 32'(err_count), 32'd0);
    check({tag, "_ffs"}, 32'(first_fail_step), 32'd7);
    check({tag, "_en_sr"}, 32'({dut_en, dut_sr}), 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    sr = 1'b0;
    check_idle("reset");
    repeat (3) @(negedge clk);
    check("idle_no_autostart", 32'(busy), 32'd0);

    // Ideal loopback, then DONE must persist without a start
    pulse_run(0, 7);
    repeat (3) @(negedge clk);
    check("done_holds", 32'({done, pass, busy}), 32'b110);

    // Single stuck bits and a full inversion
    sa0[17] = 1'b1;
    pulse_run(7, 1);
    sa0 = '0;
    sa0[16] = 1'b1;
    pulse_run(4, 3);
    sa0 = '0;
    sa1[1] = 1'b1;
    pulse_run(5, 0);
    sa1 = '0;
    inv = '1;
    pulse_run(512, 0);
    inv = '0;
    // Fresh run after a failing one
    pulse_run(0, 7);

    // Reset in the middle of step 4 of an inverted run
    inv = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4 * HOLD; c++) begin
      check("abort_stim", 32'({dut_en, dut_sr}),
            32'({tab_en[3'(c / HOLD)], tab_sr[3'(c / HOLD)]}));
      @(negedge clk);
    end
    check("step4_en_sr", 32'({dut_en, dut_sr}), 32'b11);
    check("step4_err", 32'(err_count), 32'd256);
    check("step4_ffs", 32'(first_fail_step), 32'd0);
    sr = 1'b1;
    @(negedge clk);
    sr = 1'b0;
    inv = '0;
    check_idle("abort");
    @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    pulse_run(0, 7);

    // start held high: one full run per DONE->RUN entry, no mid-run restart
    start = 1'b1;
    sb.push_back('{0, 7, 1'b1});
    @(negedge clk);
    collect();
    sa0[17] = 1'b1;
    sb.push_back('{7, 1, 1'b0});
    @(negedge clk);
    check("rerun_done_drops", 32'({busy, done}), 32'b10);
    collect();
    start = 1'b0;
    sa0 = '0;
    @(negedge clk);
    check("held_release_done", 32'({done, busy}), 32'b10);
    @(negedge clk);
    check("held_release_stays", 32'({done, busy, pass}), 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
